// File: rtl/serial_magnitude_comparator.sv
// ============================================================================
// serial_magnitude_comparator: bit-serial unsigned a/b compare, MSB first,
// fixed WIDTH-cycle latency.  Revision: 1.0
// ============================================================================
`default_nettype none

module serial_magnitude_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             gt_o,
  output logic             eq_o,
  output logic             lt_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] R_EQ = 2'd0;
  localparam logic [1:0] R_GT = 2'd1;
  localparam logic [1:0] R_LT = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic             decided_q, decided_d;
  logic [1:0]       res_q, res_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             gt_q, gt_d;
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    decided_d = decided_q;
    res_d     = res_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    gt_d      = gt_q;
    eq_d      = eq_q;
    lt_d      = lt_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
        if (start_i) begin
          a_sh_d    = a_i;
          b_sh_d    = b_i;
          cnt_d     = CNT_W'(WIDTH - 1);
          decided_d = 1'b0;
          res_d     = R_EQ;
          busy_d    = 1'b1;
          state_d   = S_SHIFT;
        end
      end

      S_SHIFT: begin
        // First differing bit from the MSB settles the result; later bits are ignored.
        if (!decided_q && (a_sh_q[WIDTH-1] != b_sh_q[WIDTH-1])) begin
          res_d     = a_sh_q[WIDTH-1] ? R_GT : R_LT;
          decided_d = 1'b1;
        end
        a_sh_d = a_sh_q << 1;
        b_sh_d = b_sh_q << 1;
        if (cnt_q == '0) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          gt_d    = (res_d == R_GT);
          eq_d    = (res_d == R_EQ);
          lt_d    = (res_d == R_LT);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      decided_q <= 1'b0;
      res_q     <= R_EQ;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      gt_q      <= 1'b0;
      eq_q      <= 1'b0;
      lt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      decided_q <= decided_d;
      res_q     <= res_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      gt_q      <= gt_d;
      eq_q      <= eq_d;
      lt_q      <= lt_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign gt_o   = gt_q;
  assign eq_o   = eq_q;
  assign lt_o   = lt_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_magnitude_comparator.sv
// ============================================================================
// tb_serial_magnitude_comparator: directed vectors for WIDTH=4 and WIDTH=1.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_serial_magnitude_comparator;

  logic       clk;
  logic       rst;
  logic       start4, start1;
  logic [3:0] a4, b4;
  logic [0:0] a1, b1;
  logic       busy4, done4, gt4, eq4, lt4;
  logic       busy1, done1, gt1, eq1, lt1;

  int n_vec;
  int n_err;
  logic [2:0] prev_flags;  // expected {gt,eq,lt} held from the last done

  serial_magnitude_comparator #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .start_i(start4), .a_i(a4), .b_i(b4),
    .busy_o(busy4), .done_o(done4), .gt_o(gt4), .eq_o(eq4), .lt_o(lt4)
  );

  serial_magnitude_comparator #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .start_i(start1), .a_i(a1), .b_i(b1),
    .busy_o(busy1), .done_o(done1), .gt_o(gt1), .eq_o(eq1), .lt_o(lt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one WIDTH=4 op from the current cycle and check every cycle up to done.
  // inject=1 pulses a competing start with a=15,b=0 in the middle of SHIFT.
  task automatic run4(input string tag, input logic [3:0] a, input logic [3:0] b,
                      input logic [2:0] exp_flags, input bit inject);
    start4 = 1'b1;
    a4 = a;
    b4 = b;
    tick();
    start4 = 1'b0;
    a4 = ~a;
    b4 = ~b;
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_busy"}, {31'd0, busy4}, 32'd1);
      chk({tag, "_nodone"}, {31'd0, done4}, 32'd0);
      chk({tag, "_hold"}, {29'd0, gt4, eq4, lt4}, {29'd0, prev_flags});
      if (inject && i == 1) begin
        start4 = 1'b1;
        a4 = 4'd15;
        b4 = 4'd0;
      end else begin
        start4 = 1'b0;
      end
      tick();
    end
    chk({tag, "_done"}, {31'd0, done4}, 32'd1);
    chk({tag, "_idle"}, {31'd0, busy4}, 32'd0);
    chk({tag, "_flags"}, {29'd0, gt4, eq4, lt4}, {29'd0, exp_flags});
    prev_flags = exp_flags;
  endtask

  task automatic run1(input string tag, input logic a, input logic b,
                      input logic [2:0] exp_flags);
    start1 = 1'b1;
    a1 = a;
    b1 = b;
    tick();
    start1 = 1'b0;
    chk({tag, "_busy"}, {30'd0, busy1, done1}, 32'b10);
    tick();
    chk({tag, "_done"}, {30'd0, busy1, done1}, 32'b01);
    chk({tag, "_flags"}, {29'd0, gt1, eq1, lt1}, {29'd0, exp_flags});
    tick();
    chk({tag, "_drop"}, {31'd0, done1}, 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    prev_flags = 3'b000;
    rst = 1'b1;
    start4 = 1'b0; a4 = '0; b4 = '0;
    start1 = 1'b0; a1 = '0; b1 = '0;
    tick();
    tick();
    chk("rst_w4", {27'd0, busy4, done4, gt4, eq4, lt4}, 32'd0);
    chk("rst_w1", {27'd0, busy1, done1, gt1, eq1, lt1}, 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_w4", {27'd0, busy4, done4, gt4, eq4, lt4}, 32'd0);

    run4("t1_9v6", 4'd9, 4'd6, 3'b100, 1'b0);
    tick();
    chk("t1_pulse", {31'd0, done4}, 32'd0);

    run4("t2_5v5", 4'd5, 4'd5, 3'b010, 1'b0);
    tick();
    run4("t2_3v12", 4'd3, 4'd12, 3'b001, 1'b0);
    tick();

    // 8 vs 7 decides on the MSB; then a back-to-back op accepted in the DONE cycle.
    run4("t3_8v7", 4'd8, 4'd7, 3'b100, 1'b0);
    run4("t4_b2b_0v15", 4'd0, 4'd15, 3'b001, 1'b0);
    tick();

    run4("t5_inject_2v2", 4'd2, 4'd2, 3'b010, 1'b1);
    tick();
    chk("t5_ignored", {30'd0, busy4, done4}, 32'd0);

    // Reset in the middle of SHIFT aborts the op and clears all outputs.
    start4 = 1'b1; a4 = 4'd9; b4 = 4'd6;
    tick();
    start4 = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_rst_outs", {27'd0, busy4, done4, gt4, eq4, lt4}, 32'd0);
    for (int i = 0; i < 6; i++) begin
      chk("t5_rst_nodone", {30'd0, busy4, done4}, 32'd0);
      tick();
    end
    prev_flags = 3'b000;

    run1("t6_00", 1'b0, 1'b0, 3'b010);
    run1("t6_01", 1'b0, 1'b1, 3'b001);
    run1("t6_10", 1'b1, 1'b0, 3'b100);
    run1("t6_11", 1'b1, 1'b1, 3'b010);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
